// File: rtl/openram_arb_pkg.sv
// Shared types and geometry for the two-port Wishbone front end of the 32x256 OpenRAM macro.
package openram_arb_pkg;

    localparam int unsigned SRAM_AW = 8;
    localparam int unsigned SRAM_DW = 32;
    localparam int unsigned SRAM_MW = SRAM_DW / 8;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        WAIT,
        ACK
    } arb_state_t;

    typedef enum logic {
        PORT_A,
        PORT_B
    } port_id_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin pick: a lone requester wins, contention goes to the port not served last.
module rr_arbiter2
    import openram_arb_pkg::*;
(
    input  logic     req_a,
    input  logic     req_b,
    input  port_id_t last_grant,
    output port_id_t grant
);

    always_comb begin
        grant = PORT_A;
        if (req_a && req_b) begin
            grant = (last_grant == PORT_A) ? PORT_B : PORT_A;
        end else if (req_b) begin
            grant = PORT_B;
        end
    end

endmodule

// File: rtl/wb_openram_arbiter.sv
// Shares the SRAM rw port between two Wishbone classic slaves; one access in flight,
// fixed 3-cycle stb-to-ack latency, round-robin on contention.
module wb_openram_arbiter
    import openram_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = SRAM_AW,
    parameter int unsigned DATA_WIDTH = SRAM_DW
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,

    input  logic                    wbs_a_cyc_i,
    input  logic                    wbs_a_stb_i,
    input  logic                    wbs_a_we_i,
    input  logic [DATA_WIDTH/8-1:0] wbs_a_sel_i,
    input  logic [31:0]             wbs_a_adr_i,
    input  logic [DATA_WIDTH-1:0]   wbs_a_dat_i,
    output logic                    wbs_a_ack_o,
    output logic [DATA_WIDTH-1:0]   wbs_a_dat_o,

    input  logic                    wbs_b_cyc_i,
    input  logic                    wbs_b_stb_i,
    input  logic                    wbs_b_we_i,
    input  logic [DATA_WIDTH/8-1:0] wbs_b_sel_i,
    input  logic [31:0]             wbs_b_adr_i,
    input  logic [DATA_WIDTH-1:0]   wbs_b_dat_i,
    output logic                    wbs_b_ack_o,
    output logic [DATA_WIDTH-1:0]   wbs_b_dat_o,

    output logic                    clk0,
    output logic                    csb0,
    output logic                    web0,
    output logic [DATA_WIDTH/8-1:0] wmask0,
    output logic [ADDR_WIDTH-1:0]   addr0,
    output logic [DATA_WIDTH-1:0]   din0,
    input  logic [DATA_WIDTH-1:0]   dout0
);

    localparam int unsigned MW = DATA_WIDTH / 8;

    arb_state_t state, state_n;
    port_id_t   last_grant, grant, cur_port;
    logic       req_a, req_b;
    logic       cur_we, cur_cyc, aborted;

    logic                  g_we;
    logic [MW-1:0]         g_sel;
    logic [31:0]           g_adr;
    logic [DATA_WIDTH-1:0] g_dat;
    logic                  unused_adr_bits;

    assign clk0    = wb_clk_i;
    assign req_a   = wbs_a_cyc_i & wbs_a_stb_i;
    assign req_b   = wbs_b_cyc_i & wbs_b_stb_i;
    assign cur_cyc = (cur_port == PORT_A) ? wbs_a_cyc_i : wbs_b_cyc_i;

    // Decode above the word address happens upstream.
    assign unused_adr_bits = ^{g_adr[31:ADDR_WIDTH+2], g_adr[1:0]};

    rr_arbiter2 u_rr (
        .req_a      (req_a),
        .req_b      (req_b),
        .last_grant (last_grant),
        .grant      (grant)
    );

    always_comb begin
        g_we  = wbs_a_we_i;
        g_sel = wbs_a_sel_i;
        g_adr = wbs_a_adr_i;
        g_dat = wbs_a_dat_i;
        if (grant == PORT_B) begin
            g_we  = wbs_b_we_i;
            g_sel = wbs_b_sel_i;
            g_adr = wbs_b_adr_i;
            g_dat = wbs_b_dat_i;
        end

        state_n = state;
        unique case (state)
            IDLE: if (req_a || req_b) state_n = CMD;
            CMD:  state_n = WAIT;
            WAIT: state_n = ACK;
            ACK:  state_n = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) state <= IDLE;
        else          state <= state_n;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            csb0        <= 1'b1;
            web0        <= 1'b1;
            wmask0      <= '0;
            addr0       <= '0;
            din0        <= '0;
            wbs_a_ack_o <= 1'b0;
            wbs_b_ack_o <= 1'b0;
            wbs_a_dat_o <= '0;
            wbs_b_dat_o <= '0;
            last_grant  <= PORT_B;
            cur_port    <= PORT_A;
            cur_we      <= 1'b0;
            aborted     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_a || req_b) begin
                        addr0      <= g_adr[ADDR_WIDTH+1:2];
                        din0       <= g_dat;
                        wmask0     <= g_we ? g_sel : '0;
                        web0       <= ~g_we;
                        csb0       <= 1'b0;
                        last_grant <= grant;
                        cur_port   <= grant;
                        cur_we     <= g_we;
                        aborted    <= 1'b0;
                    end else begin
                        csb0 <= 1'b1;
                    end
                end
                CMD: begin
                    csb0 <= 1'b1;
                    web0 <= 1'b1;
                    // The SRAM access cannot be cancelled; a dropped cycle only suppresses the ack.
                    if (!cur_cyc) aborted <= 1'b1;
                end
                WAIT: begin
                    if (cur_port == PORT_A) begin
                        wbs_a_dat_o <= cur_we ? '0 : dout0;
                        wbs_a_ack_o <= wbs_a_cyc_i && !aborted;
                    end else begin
                        wbs_b_dat_o <= cur_we ? '0 : dout0;
                        wbs_b_ack_o <= wbs_b_cyc_i && !aborted;
                    end
                end
                ACK: begin
                    wbs_a_ack_o <= 1'b0;
                    wbs_b_ack_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
